// File: rtl/i2c_master_pkg.sv
// Shared types and constants for the I2C master bit engine.
package i2c_master_pkg;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_STOP  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BIT,
        S_ACK,
        S_STOP,
        S_RESP
    } state_t;

    typedef logic [1:0] phase_t;

    localparam int DEFAULT_CLK_DIV = 250;

endpackage

// File: rtl/i2c_master_core_quarter_tick.sv
// SCL quarter-period divider; holds at zero while the bus is stretched.
module i2c_quarter_tick #(
    parameter int CLK_DIV = 250
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic hold,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else if (!run || hold || count == LAST)
            count <= '0;
        else
            count <= count + 1'b1;
    end

    assign tick = run & ~hold & (count == LAST);

endmodule

// File: rtl/i2c_master_core.sv
// Byte-level I2C master: START / WRITE / READ / STOP over valid/ready,
// open-drain output enables only.
module i2c_master_core
    import i2c_master_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic       cmd_nack,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_ack_err,
    output logic       busy,
    output logic       bus_active,
    input  logic       scl_i,
    output logic       scl_oe,
    input  logic       sda_i,
    output logic       sda_oe
);

    state_t     state;
    state_t     state_next;
    phase_t     phase;
    op_t        op_q;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic [7:0] data_q;
    logic       nack_q;
    logic       samp;
    logic       sda_hold;
    logic       run;
    logic       hold;
    logic       tick;
    logic       accept;
    logic       last_q;

    assign accept = cmd_valid & cmd_ready;
    assign last_q = tick & (phase == 2'd3);
    // A released SCL held low by a slave freezes the divider.
    assign hold   = ~scl_oe & ~scl_i;

    i2c_quarter_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clock(clock),
        .reset(reset),
        .run  (run),
        .hold (hold),
        .tick (tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:
                if (accept) begin
                    unique case (op_t'(cmd_op))
                        OP_START: state_next = S_START;
                        OP_STOP:  state_next = S_STOP;
                        default:  state_next = S_BIT;
                    endcase
                end
            S_START:
                if (last_q) state_next = S_RESP;
            S_BIT:
                if (!bus_active)
                    state_next = S_RESP;
                else if (last_q && bit_cnt == 3'd7)
                    state_next = S_ACK;
            S_ACK:
                if (last_q) state_next = S_RESP;
            S_STOP:
                if (!bus_active || last_q) state_next = S_RESP;
            S_RESP:
                state_next = S_IDLE;
            default:
                state_next = S_IDLE;
        endcase
    end

    // Outside active phases the lines keep their parked levels.
    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        rsp_valid = (state == S_RESP);
        run       = 1'b0;
        scl_oe    = bus_active;
        sda_oe    = sda_hold;
        unique case (state)
            S_START: begin
                run    = 1'b1;
                sda_oe = phase[1];
                scl_oe = (phase == 2'd0) ? bus_active
                                         : (phase == 2'd3);
            end
            S_BIT:
                if (bus_active) begin
                    run    = 1'b1;
                    scl_oe = ~phase[1];
                    sda_oe = (op_q == OP_WRITE) & ~shreg[7];
                end
            S_ACK: begin
                run    = 1'b1;
                scl_oe = ~phase[1];
                sda_oe = (op_q == OP_READ) & ~nack_q;
            end
            S_STOP:
                if (bus_active) begin
                    run    = 1'b1;
                    scl_oe = (phase == 2'd0);
                    sda_oe = ~phase[1];
                end
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            phase       <= '0;
            op_q        <= OP_START;
            bit_cnt     <= '0;
            shreg       <= '0;
            data_q      <= '0;
            nack_q      <= 1'b0;
            samp        <= 1'b0;
            sda_hold    <= 1'b0;
            bus_active  <= 1'b0;
            rsp_data    <= '0;
            rsp_ack_err <= 1'b0;
        end else begin
            sda_hold <= sda_oe;
            if (accept) begin
                phase   <= '0;
                op_q    <= op_t'(cmd_op);
                bit_cnt <= '0;
                shreg   <= cmd_data;
                data_q  <= cmd_data;
                nack_q  <= cmd_nack;
            end else if (tick) begin
                phase <= phase + 2'd1;
                if (phase == 2'd2)
                    samp <= sda_i;
                if (phase == 2'd3 && state == S_BIT) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    shreg   <= {shreg[6:0], samp};
                end
            end
            if (state == S_START && last_q)
                bus_active <= 1'b1;
            if (state == S_STOP && last_q)
                bus_active <= 1'b0;
            if (state != S_RESP && state_next == S_RESP) begin
                rsp_data    <= '0;
                rsp_ack_err <= (state == S_BIT);
                if (state == S_ACK) begin
                    if (op_q == OP_WRITE) begin
                        rsp_data    <= data_q;
                        rsp_ack_err <= samp;
                    end else begin
                        rsp_data <= shreg;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_i2c_master_core.sv
// Directed bench for i2c_master_core: scoreboarded responses plus
// a simple open-drain slave and line-condition monitor.
module tb_i2c_master_core;
    import i2c_master_pkg::*;

    localparam int DIV = 4;
    localparam int L4  = 4 * DIV + 1;
    localparam int L36 = 36 * DIV + 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] cmd_data = 8'h00;
    logic       cmd_nack = 1'b0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_ack_err;
    logic       busy;
    logic       bus_active;
    logic       scl_i;
    logic       scl_oe;
    logic       sda_i;
    logic       sda_oe;

    always #5 clock = ~clock;

    i2c_master_core #(.CLK_DIV(DIV)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_nack(cmd_nack),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .rsp_ack_err(rsp_ack_err), .busy(busy),
        .bus_active(bus_active),
        .scl_i(scl_i), .scl_oe(scl_oe),
        .sda_i(sda_i), .sda_oe(sda_oe)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rsp_cnt = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave model: bit index = SCL falls since the command was issued.
    int         falls = 0;
    int         base = 0;
    int         slave_mode = 0;
    logic [7:0] slave_byte = 8'h00;
    logic       stretch_arm = 1'b0;
    int         stretch_left = 0;
    int         k;
    logic       slave_pull;
    logic       stretch_on;

    always_comb begin
        k = falls - base;
        slave_pull = 1'b0;
        if (slave_mode == 1)
            slave_pull = (k == 8);
        else if (slave_mode == 2 && k >= 0 && k < 8)
            slave_pull = ~slave_byte[3'(7 - k)];
        stretch_on = stretch_arm && (k == 3) && (stretch_left > 0);
    end

    assign scl_i = ~scl_oe & ~stretch_on;
    assign sda_i = ~sda_oe & ~slave_pull;

    always @(posedge clock)
        if (stretch_on && !scl_oe) stretch_left <= stretch_left - 1;

    logic pscl = 1'b1;
    logic psda = 1'b1;
    int   start_cnt = 0;
    int   stop_cnt = 0;
    logic oe_seen = 1'b0;
    logic rise_sda[$];
    logic rise_oe[$];

    always @(negedge clock) begin
        if (!pscl && scl_i) begin
            rise_sda.push_back(sda_i);
            rise_oe.push_back(sda_oe);
        end
        if (pscl && !scl_i) falls++;
        if (pscl && scl_i && psda && !sda_i) start_cnt++;
        if (pscl && scl_i && !psda && sda_i) stop_cnt++;
        if (scl_oe || sda_oe) oe_seen = 1'b1;
        pscl = scl_i;
        psda = sda_i;
    end

    typedef struct {
        string      name;
        int         lat;
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    always @(negedge clock) begin
        if (!reset && rsp_valid) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: data %0h err %0h",
                         rsp_data, rsp_ack_err);
            end else begin
                mon_e = exp_q.pop_front();
                chk({mon_e.name, "_lat"}, cyc - acc_cyc + 1, mon_e.lat);
                chk({mon_e.name, "_data"}, int'(rsp_data), int'(mon_e.data));
                chk({mon_e.name, "_err"}, int'(rsp_ack_err), int'(mon_e.err));
            end
        end
    end

    task automatic issue(input string name, input op_t op,
                         input logic [7:0] data, input logic nack,
                         input int mode, input logic [7:0] sbyte,
                         input int lat, input logic [7:0] edata,
                         input logic eerr);
        int target;
        exp_t e;
        @(negedge clock);
        chk({name, "_ready"}, int'(cmd_ready), 1);
        rise_sda.delete();
        rise_oe.delete();
        base = falls;
        slave_mode = mode;
        slave_byte = sbyte;
        e.name = name;
        e.lat = lat;
        e.data = edata;
        e.err = eerr;
        exp_q.push_back(e);
        target = rsp_cnt;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_data = data;
        cmd_nack = nack;
        @(posedge clock);
        #1;
        acc_cyc = cyc;
        cmd_valid = 1'b0;
        for (int i = 0; i < 1000 && rsp_cnt == target; i++)
            @(negedge clock);
        if (rsp_cnt == target) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: got no rsp expected rsp", name);
            exp_q.delete();
        end
        slave_mode = 0;
    endtask

    task automatic check_bits(input string name, input logic [7:0] exp);
        logic [7:0] got;
        got = 8'h00;
        chk({name, "_rises"}, rise_sda.size(), 9);
        if (rise_sda.size() >= 8)
            for (int i = 0; i < 8; i++) got[7-i] = rise_sda[i];
        chk({name, "_bits"}, int'(got), int'(exp));
    endtask

    int s0;
    int st0;
    int r0;

    initial begin
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_bus", int'(bus_active), 0);
        chk("rst_rspv", int'(rsp_valid), 0);
        chk("rst_rspd", int'(rsp_data), 0);
        chk("rst_err", int'(rsp_ack_err), 0);
        chk("rst_scl", int'(scl_oe), 0);
        chk("rst_sda", int'(sda_oe), 0);

        // Reset in the middle of a WRITE
        issue("start0", OP_START, 8'h00, 1'b0, 0, 8'h00, L4, 8'h00, 1'b0);
        @(negedge clock);
        r0 = rsp_cnt;
        cmd_valid = 1'b1;
        cmd_op = OP_WRITE;
        cmd_data = 8'h00;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        repeat (29) @(negedge clock);
        chk("prerst_sda", int'(sda_oe), 1);
        reset = 1'b1;
        @(negedge clock);
        chk("inrst_scl", int'(scl_oe), 0);
        chk("inrst_sda", int'(sda_oe), 0);
        reset = 1'b0;
        repeat (200) @(negedge clock);
        chk("postrst_ready", int'(cmd_ready), 1);
        chk("postrst_bus", int'(bus_active), 0);
        chk("postrst_norsp", rsp_cnt, r0);

        // START, WRITE 0xA5 acked
        issue("start1", OP_START, 8'h00, 1'b0, 0, 8'h00, L4, 8'h00, 1'b0);
        chk("start1_bus", int'(bus_active), 1);
        issue("wr_a5", OP_WRITE, 8'hA5, 1'b0, 1, 8'h00, L36, 8'hA5, 1'b0);
        check_bits("wr_a5", 8'hA5);

        // WRITE with no slave, then STOP
        issue("wr_3c", OP_WRITE, 8'h3C, 1'b0, 0, 8'h00, L36, 8'h3C, 1'b1);
        chk("wr_3c_bus", int'(bus_active), 1);
        s0 = stop_cnt;
        issue("stop1", OP_STOP, 8'h00, 1'b0, 0, 8'h00, L4, 8'h00, 1'b0);
        chk("stop1_cond", stop_cnt - s0, 1);
        chk("stop1_bus", int'(bus_active), 0);

        // READ with NACK then READ with ACK
        issue("start2", OP_START, 8'h00, 1'b0, 0, 8'h00, L4, 8'h00, 1'b0);
        issue("rd_96", OP_READ, 8'h00, 1'b1, 2, 8'h96, L36, 8'h96, 1'b0);
        if (rise_oe.size() >= 9)
            chk("rd_96_ack_oe", int'(rise_oe[8]), 0);
        else
            chk("rd_96_rises", rise_oe.size(), 9);
        issue("rd_5a", OP_READ, 8'h00, 1'b0, 2, 8'h5A, L36, 8'h5A, 1'b0);
        if (rise_oe.size() >= 9)
            chk("rd_5a_ack_oe", int'(rise_oe[8]), 1);
        else
            chk("rd_5a_rises", rise_oe.size(), 9);
        issue("stop2", OP_STOP, 8'h00, 1'b0, 0, 8'h00, L4, 8'h00, 1'b0);

        // Clock stretch in bit 3
        issue("start3", OP_START, 8'h00, 1'b0, 0, 8'h00, L4, 8'h00, 1'b0);
        stretch_left = 20;
        stretch_arm = 1'b1;
        issue("wr_st", OP_WRITE, 8'h81, 1'b0, 1, 8'h00, L36 + 20, 8'h81, 1'b0);
        check_bits("wr_st", 8'h81);
        stretch_arm = 1'b0;
        issue("stop3", OP_STOP, 8'h00, 1'b0, 0, 8'h00, L4, 8'h00, 1'b0);

        // WRITE with bus idle
        @(negedge clock);
        oe_seen = 1'b0;
        issue("wr_nobus", OP_WRITE, 8'h5A, 1'b0, 0, 8'h00, 2, 8'h00, 1'b1);
        @(negedge clock);
        chk("wr_nobus_oe", int'(oe_seen), 0);

        // Repeated START between two WRITEs
        s0 = stop_cnt;
        st0 = start_cnt;
        issue("start4", OP_START, 8'h00, 1'b0, 0, 8'h00, L4, 8'h00, 1'b0);
        issue("wr_11", OP_WRITE, 8'h11, 1'b0, 1, 8'h00, L36, 8'h11, 1'b0);
        issue("rstart", OP_START, 8'h00, 1'b0, 0, 8'h00, L4, 8'h00, 1'b0);
        issue("wr_22", OP_WRITE, 8'h22, 1'b0, 1, 8'h00, L36, 8'h22, 1'b0);
        check_bits("wr_22", 8'h22);
        chk("rstart_starts", start_cnt - st0, 2);
        chk("rstart_nostop", stop_cnt - s0, 0);
        issue("stop4", OP_STOP, 8'h00, 1'b0, 0, 8'h00, L4, 8'h00, 1'b0);
        chk("end_bus", int'(bus_active), 0);

        repeat (5) @(negedge clock);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
